// File: rtl/uart_frame_parser_if.sv
// UART command-frame parser bus: received byte stream in, decoded command / error out.
interface uart_frame_parser_if #(
    parameter int unsigned MAX_PARA_BYTES = 8
);
    localparam int unsigned PL_W = 8 * MAX_PARA_BYTES;

    logic            i_rx_en;
    logic [7:0]      i_rx_data;
    logic            o_cmd_valid;
    logic [7:0]      o_cmdcode;
    logic [7:0]      o_cmd_len;
    logic [7:0]      o_para_cnt;
    logic [PL_W-1:0] o_para_list;
    logic            o_err_valid;
    logic [1:0]      o_err_code;
    logic            o_busy;

    // Byte source / command consumer side
    modport master (
        output i_rx_en, i_rx_data,
        input  o_cmd_valid, o_cmdcode, o_cmd_len, o_para_cnt, o_para_list,
        input  o_err_valid, o_err_code, o_busy
    );

    // Parser side
    modport slave (
        input  i_rx_en, i_rx_data,
        output o_cmd_valid, o_cmdcode, o_cmd_len, o_para_cnt, o_para_list,
        output o_err_valid, o_err_code, o_busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// UART command-frame parser: HEADER, LEN, CMD, PARA x (LEN-1), CHECK.
// Define FRAME_CHECKSUM_EN to verify the additive checksum; otherwise the
// CHECK byte is consumed and ignored.
module uart_frame_parser #(
    parameter int unsigned MAX_PARA_BYTES = 8,
    parameter logic [7:0]  HEADER         = 8'h40,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic               clk,
    input logic               rst_n,
    uart_frame_parser_if.slave bus
);
    localparam int unsigned PL_W  = 8 * MAX_PARA_BYTES;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_CMD, ST_PARA, ST_CHECK} state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        idx_q, idx_d;
    logic [PL_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmdcode_q, cmdcode_d;
    logic [7:0]        cmd_len_q, cmd_len_d;
    logic [7:0]        para_cnt_q, para_cnt_d;
    logic [PL_W-1:0]   para_list_q, para_list_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              busy_q, busy_d;
    logic              len_bad;
    logic              frame_ok;

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cmd_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            tmo_q       <= '0;
`ifdef FRAME_CHECKSUM_EN
            sum_q       <= '0;
`endif
            cmd_valid_q <= 1'b0;
            cmdcode_q   <= '0;
            cmd_len_q   <= '0;
            para_cnt_q  <= '0;
            para_list_q <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            tmo_q       <= tmo_d;
`ifdef FRAME_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
            cmd_valid_q <= cmd_valid_d;
            cmdcode_q   <= cmdcode_d;
            cmd_len_q   <= cmd_len_d;
            para_cnt_q  <= para_cnt_d;
            para_list_q <= para_list_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
`ifdef FRAME_CHECKSUM_EN
        sum_d       = sum_q;
        frame_ok    = (bus.i_rx_data == sum_q);
`else
        frame_ok    = 1'b1;
`endif
        cmd_valid_d = 1'b0;
        cmdcode_d   = cmdcode_q;
        cmd_len_d   = cmd_len_q;
        para_cnt_d  = para_cnt_q;
        para_list_d = para_list_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        len_bad     = (bus.i_rx_data == 8'd0) ||
                      (32'(bus.i_rx_data) > MAX_PARA_BYTES + 32'd1);

        // Inter-byte idle counter; parked at zero while hunting for a header
        if (state_q == ST_IDLE || bus.i_rx_en) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + CNT_W'(1);
        end

        if (bus.i_rx_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_rx_data == HEADER) begin
                        buf_d   = '0;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (len_bad) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d   = bus.i_rx_data;
                        idx_d   = '0;
`ifdef FRAME_CHECKSUM_EN
                        sum_d   = bus.i_rx_data;
`endif
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    cmd_d   = bus.i_rx_data;
`ifdef FRAME_CHECKSUM_EN
                    sum_d   = sum_q + bus.i_rx_data;
`endif
                    state_d = (len_q > 8'd1) ? ST_PARA : ST_CHECK;
                end
                ST_PARA: begin
                    for (int i = 0; i < int'(MAX_PARA_BYTES); i++) begin
                        if (idx_q == 8'(i)) buf_d[i*8 +: 8] = bus.i_rx_data;
                    end
`ifdef FRAME_CHECKSUM_EN
                    sum_d = sum_q + bus.i_rx_data;
`endif
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'(len_q - 8'd2)) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        cmd_valid_d = 1'b1;
                        cmdcode_d   = cmd_q;
                        cmd_len_d   = len_q;
                        para_cnt_d  = len_q - 8'd1;
                        para_list_d = buf_q;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = 2'd1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Stalled frame: this is the final allowed idle cycle
            err_valid_d = 1'b1;
            err_code_d  = 2'd3;
            tmo_d       = '0;
            state_d     = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.o_cmd_valid = cmd_valid_q;
    assign bus.o_cmdcode   = cmdcode_q;
    assign bus.o_cmd_len   = cmd_len_q;
    assign bus.o_para_cnt  = para_cnt_q;
    assign bus.o_para_list = para_list_q;
    assign bus.o_err_valid = err_valid_q;
    assign bus.o_err_code  = err_code_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser (MAX_PARA_BYTES=8, TIMEOUT_CYCLES=100).
module tb_uart_frame_parser;
    localparam int unsigned MAXP = 8;
    localparam int unsigned TMO  = 100;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic [7:0]  pcnt;
        logic [63:0] plist;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    uart_frame_parser_if #(.MAX_PARA_BYTES(MAXP)) bus ();

    uart_frame_parser #(
        .MAX_PARA_BYTES(MAXP),
        .HEADER        (8'h40),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_en   = 1'b1;
        bus.i_rx_data = b;
        @(posedge clk);
        #1 bus.i_rx_en = 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] cmd, input logic [7:0] len, input logic [63:0] pl);
        exp_t e;
        e.is_err = 1'b0; e.code = 2'd0; e.cmd = cmd; e.len = len;
        e.pcnt = len - 8'd1; e.plist = pl;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.cmd = '0; e.len = '0; e.pcnt = '0; e.plist = '0;
        sb.push_back(e);
    endtask

    // Well-formed frame with n parameter bytes taken from the low bytes of pl_in
    task automatic send_good(input logic [7:0] cmd, input int n, input logic [63:0] pl_in);
        logic [63:0] pl;
        logic [7:0]  len;
        logic [7:0]  s;
        pl  = '0;
        len = 8'(n + 1);
        s   = len + cmd;
        for (int i = 0; i < n; i++) begin
            pl[i*8 +: 8] = pl_in[i*8 +: 8];
            s = s + pl_in[i*8 +: 8];
        end
        push_cmd(cmd, len, pl);
        send_byte(8'h40);
        send_byte(len);
        send_byte(cmd);
        for (int i = 0; i < n; i++) send_byte(pl[i*8 +: 8]);
        send_byte(s);
    endtask

    task automatic expect_pulse(input string tag, input bit is_err);
        @(negedge clk);
        check_eq(tag, is_err ? bus.o_err_valid : bus.o_cmd_valid, 1'b1);
    endtask

    task automatic check_held(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                              input logic [63:0] pl);
        check_eq({tag, "_cmd"}, bus.o_cmdcode, cmd);
        check_eq({tag, "_len"}, bus.o_cmd_len, len);
        check_eq({tag, "_pcnt"}, bus.o_para_cnt, len - 8'd1);
        check_eq({tag, "_plist"}, bus.o_para_list, pl);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_cv"}, bus.o_cmd_valid, 0);
        check_eq({tag, "_cmd"}, bus.o_cmdcode, 0);
        check_eq({tag, "_len"}, bus.o_cmd_len, 0);
        check_eq({tag, "_pcnt"}, bus.o_para_cnt, 0);
        check_eq({tag, "_plist"}, bus.o_para_list, 0);
        check_eq({tag, "_ev"}, bus.o_err_valid, 0);
        check_eq({tag, "_ecode"}, bus.o_err_code, 0);
        check_eq({tag, "_busy"}, bus.o_busy, 0);
    endtask

    // Scoreboard monitor: every strobe pops and checks one expected result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.o_cmd_valid || bus.o_err_valid)) begin
            if (bus.o_cmd_valid && bus.o_err_valid) check_eq("both_strobes", 1, 0);
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("sb_kind", bus.o_err_valid, e.is_err);
                if (e.is_err) begin
                    check_eq("sb_err_code", bus.o_err_code, e.code);
                end else begin
                    check_eq("sb_cmd", bus.o_cmdcode, e.cmd);
                    check_eq("sb_len", bus.o_cmd_len, e.len);
                    check_eq("sb_pcnt", bus.o_para_cnt, e.pcnt);
                    check_eq("sb_plist", bus.o_para_list, e.plist);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.i_rx_en   = 1'b0;
        bus.i_rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reference good frame 40 03 12 AA 55 14
        send_good(8'h12, 2, 64'h55AA);
        expect_pulse("good_lat", 0);
        @(negedge clk);
        check_held("good_hold", 8'h12, 8'h03, 64'h55AA);

        // Checksum mismatch: 40 02 34 77 AE (correct would be AD)
`ifdef FRAME_CHECKSUM_EN
        push_err(2'd1);
`else
        push_cmd(8'h34, 8'h02, 64'h77);
`endif
        send_byte(8'h40); send_byte(8'h02); send_byte(8'h34); send_byte(8'h77); send_byte(8'hAE);
`ifdef FRAME_CHECKSUM_EN
        expect_pulse("badsum_lat", 1);
        @(negedge clk);
        check_held("badsum_hold", 8'h12, 8'h03, 64'h55AA);
`else
        expect_pulse("nosum_lat", 0);
        @(negedge clk);
        check_held("nosum_hold", 8'h34, 8'h02, 64'h77);
`endif

        // Length too large (LEN-1 = 9 > 8), then minimal frame right after
        push_err(2'd2);
        send_byte(8'h40); send_byte(8'h0A);
        expect_pulse("len_big_lat", 1);
        push_cmd(8'h07, 8'h01, 64'h0);
        send_byte(8'h40); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
        expect_pulse("len1_lat", 0);

        // Zero length rejected
        push_err(2'd2);
        send_byte(8'h40); send_byte(8'h00);
        expect_pulse("len0_lat", 1);

        // Largest legal frame, then a back-to-back frame with no gap
        send_good(8'h01, 8, 64'h0807060504030201);
        send_good(8'h12, 2, 64'h55AA);
        expect_pulse("b2b_lat", 0);

        // Header hunt: leading junk dropped, mid-frame 0x40 is payload
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3F);
        send_good(8'h40, 3, 64'h40_40_40);

        // Randomised frames across all legal lengths
        for (int k = 0; k < 10; k++) begin
            send_good(8'($urandom), int'($urandom_range(0, 8)), {$urandom, $urandom});
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Timeout: 40 03 then stall for exactly TMO idle cycles
        push_err(2'd3);
        send_byte(8'h40); send_byte(8'h03);
        seen = 1'b0;
        for (int c = 0; c < int'(TMO); c++) begin
            @(negedge clk);
            if (bus.o_err_valid || !bus.o_busy) seen = 1'b1;
        end
        check_eq("tmo_early", seen, 0);
        @(negedge clk);
        check_eq("tmo_pulse", bus.o_err_valid, 1);
        check_eq("tmo_busy", bus.o_busy, 0);

        // Byte arriving on idle cycle TMO wins over the timeout
        push_cmd(8'h12, 8'h03, 64'h55AA);
        send_byte(8'h40); send_byte(8'h03);
        repeat (int'(TMO) - 1) @(posedge clk);
        #1;
        send_byte(8'h12); send_byte(8'hAA); send_byte(8'h55); send_byte(8'h14);
        expect_pulse("tmo_race_lat", 0);

        // Mid-frame reset discards the partial frame and clears outputs
        send_byte(8'h40); send_byte(8'h03); send_byte(8'h12);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        #1;
        send_good(8'h12, 2, 64'h55AA);
        expect_pulse("postrst_lat", 0);

        repeat (5) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
